// File: rtl/mp_add_seq_if.sv
// ---------------------------------------------------------------------------
// mp_add_seq_if
// Command/result bundle for the word-serial multi-precision adder.
//
// Handshake: the master raises start with operands valid; the slave samples
// start only while idle (busy=0) and captures sub/nwords/a/b on that edge.
// There is no ready signal: busy=1 means any start is ignored (no queuing).
// Completion is a single-cycle done pulse; z and the flags are final
// from that cycle on and hold until the next accepted start.
//
// Signals (master view):
//   start    out  request a new operation
//   sub      out  0 = A+B, 1 = A-B
//   nwords   out  operand length in 16-bit words, minus 1
//   a, b     out  64-bit operands, word k = [16k+15:16k]
//   busy     in   operation in progress (RUN or DONE)
//   done     in   one-cycle completion pulse
//   z        in   result, words above nwords are 0
//   sign, zero, carry, parity, overflow  in  status flags
// ---------------------------------------------------------------------------
interface mp_add_seq_if;
   logic        start;
   logic        sub;
   logic [1:0]  nwords;
   logic [63:0] a;
   logic [63:0] b;
   logic        busy;
   logic        done;
   logic [63:0] z;
   logic        sign;
   logic        zero;
   logic        carry;
   logic        parity;
   logic        overflow;

   modport master (
      output start, sub, nwords, a, b,
      input  busy, done, z, sign, zero, carry, parity, overflow
   );

   modport slave (
      input  start, sub, nwords, a, b,
      output busy, done, z, sign, zero, carry, parity, overflow
   );
endinterface

// File: rtl/mp_add_seq.sv
// ---------------------------------------------------------------------------
// mp_add_seq
// Word-serial add/subtract of up to 64-bit operands using a single 16-bit
// adder slice. One word is processed per RUN cycle, least significant first,
// with the slice carry-out fed back as the next carry-in.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous, active-high reset
//   bus          slave modport of mp_add_seq_if (command, result, flags)
//   o_dbg_state  out  current FSM state (0 = IDLE, 1 = RUN, 2 = DONE)
// ---------------------------------------------------------------------------
module mp_add_seq (
   input  logic         clk,
   input  logic         rst,
   mp_add_seq_if.slave  bus,
   output logic [1:0]   o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic [63:0] r_a;
   logic [63:0] r_b;
   logic        r_sub;
   logic [1:0]  r_nw;
   logic [1:0]  r_k;
   logic        r_cin;
   logic [63:0] r_z;
   logic        r_sign;
   logic        r_zero;
   logic        r_carry;
   logic        r_parity;
   logic        r_ovf;

   logic        w_last;
   logic [15:0] w_a_word;
   logic [15:0] w_b_word;
   logic [15:0] w_s;
   logic        w_cout;
   logic [63:0] w_z_upd;

   // ------------------------------------------------------------------
   // Datapath: one 16-bit slice. Subtraction is A + ~B + 1, the +1 being
   // the initial carry-in loaded from sub at start.
   // ------------------------------------------------------------------
   assign w_last   = (r_state == S_RUN) && (r_k == r_nw);
   assign w_a_word = r_a[{r_k, 4'b0000} +: 16];
   assign w_b_word = r_b[{r_k, 4'b0000} +: 16] ^ {16{r_sub}};
   assign {w_cout, w_s} = {1'b0, w_a_word} + {1'b0, w_b_word} + {16'b0, r_cin};

   // Result with the current word merged in; used for the final flags so
   // zero/parity see the top word in the same edge it is written. Words
   // above nwords were cleared at start, so reducing all 64 bits only
   // sees the active ones.
   always_comb begin
      w_z_upd = r_z;
      w_z_upd[{r_k, 4'b0000} +: 16] = w_s;
   end

   // ------------------------------------------------------------------
   // FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (bus.start) w_state_nxt = S_RUN;
         S_RUN:   if (w_last)    w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Operand capture, word accumulation and flags
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_sub    <= 1'b0;
         r_nw     <= 2'd0;
         r_k      <= 2'd0;
         r_cin    <= 1'b0;
         r_z      <= '0;
         r_sign   <= 1'b0;
         r_zero   <= 1'b0;
         r_carry  <= 1'b0;
         r_parity <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.start) begin
                  r_a      <= bus.a;
                  r_b      <= bus.b;
                  r_sub    <= bus.sub;
                  r_nw     <= bus.nwords;
                  r_k      <= 2'd0;
                  r_cin    <= bus.sub;
                  r_z      <= '0;
                  r_sign   <= 1'b0;
                  r_zero   <= 1'b0;
                  r_carry  <= 1'b0;
                  r_parity <= 1'b0;
                  r_ovf    <= 1'b0;
               end
            end
            S_RUN: begin
               r_z   <= w_z_upd;
               r_cin <= w_cout;
               if (w_last) begin
                  r_carry  <= w_cout;
                  r_sign   <= w_s[15];
                  r_zero   <= ~|w_z_upd;
                  r_parity <= ~^w_z_upd;
                  // Signed overflow: like-signed inputs, differently signed sum.
                  r_ovf    <= (w_a_word[15] & w_b_word[15] & ~w_s[15]) |
                              (~w_a_word[15] & ~w_b_word[15] & w_s[15]);
               end else begin
                  r_k <= r_k + 2'd1;
               end
            end
            default: ;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.busy     = (r_state != S_IDLE);
   assign bus.done     = (r_state == S_DONE);
   assign bus.z        = r_z;
   assign bus.sign     = r_sign;
   assign bus.zero     = r_zero;
   assign bus.carry    = r_carry;
   assign bus.parity   = r_parity;
   assign bus.overflow = r_ovf;
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mp_add_seq.sv
// ---------------------------------------------------------------------------
// tb_mp_add_seq
// Self-checking bench for mp_add_seq. Expected results come from a
// full-width arithmetic model (one wide add per operation).
// ---------------------------------------------------------------------------
module tb_mp_add_seq;

   logic       clk;
   logic       rst;
   logic [1:0] dbg_state;

   int n_vec;
   int n_err;

   mp_add_seq_if bus ();

   mp_add_seq dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .o_dbg_state (dbg_state)
   );

   // ------------------------------------------------------------------
   // Clock
   // ------------------------------------------------------------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ------------------------------------------------------------------
   // Reference model: {z, sign, zero, carry, parity, overflow}
   // ------------------------------------------------------------------
   function automatic logic [68:0] model(input logic s, input logic [1:0] nw,
                                         input logic [63:0] a, input logic [63:0] b);
      int          w;
      logic [64:0] m65;
      logic [64:0] full;
      logic [63:0] mask;
      logic [63:0] am;
      logic [63:0] bm;
      logic [63:0] zz;
      logic        c, sg, zr, pr, ov;
      w    = 16 * (int'(nw) + 1);
      m65  = (65'd1 << w) - 65'd1;
      mask = m65[63:0];
      am   = a & mask;
      bm   = (s ? ~b : b) & mask;
      full = {1'b0, am} + {1'b0, bm} + {64'd0, s};
      zz   = full[63:0] & mask;
      c    = full[w];
      sg   = zz[w-1];
      zr   = (zz == 64'd0);
      pr   = ~^zz;
      ov   = (am[w-1] == bm[w-1]) && (sg != am[w-1]);
      return {zz, sg, zr, c, pr, ov};
   endfunction

   function automatic logic [63:0] rand64();
      return {$urandom, $urandom};
   endfunction

   function automatic logic [68:0] observed();
      return {bus.z, bus.sign, bus.zero, bus.carry, bus.parity, bus.overflow};
   endfunction

   // ------------------------------------------------------------------
   // Driver: called at a negedge. mode 0 = plain, 1 = start pulsed with
   // other operands while busy, 2 = operands scrambled every cycle.
   // Returns start-to-done latency in cycles, result at done, result after
   // 6 idle cycles, and number of extra done pulses in those cycles.
   // ------------------------------------------------------------------
   task automatic run_op(input logic s, input logic [1:0] nw,
                         input logic [63:0] a, input logic [63:0] b, input int mode,
                         output int lat, output logic [68:0] obs,
                         output logic [68:0] obs_hold, output int extra);
      bus.start  = 1'b1;
      bus.sub    = s;
      bus.nwords = nw;
      bus.a      = a;
      bus.b      = b;
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (bus.done !== 1'b1 && lat < 20) begin
         if (mode == 1) begin
            bus.start = 1'b1;
            bus.a     = rand64();
            bus.b     = rand64();
         end else if (mode == 2) begin
            bus.a      = rand64();
            bus.b      = rand64();
            bus.sub    = 1'($urandom_range(0, 1));
            bus.nwords = 2'($urandom_range(0, 3));
         end
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) lat = 99;
      obs = observed();
      // A start still high here is seen in the DONE cycle and must be ignored.
      @(negedge clk);
      bus.start = 1'b0;
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.done === 1'b1) extra++;
         @(negedge clk);
      end
      obs_hold = observed();
   endtask

   // ------------------------------------------------------------------
   // Tests
   // ------------------------------------------------------------------
   task automatic test_reset();
      int          lat, extra;
      logic [68:0] obs, hold;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_err++;
         $display("FAIL reset_ctl: busy=%b done=%b, want 0 0", bus.busy, bus.done);
      end
      n_vec++;
      if (observed() !== 69'd0) begin
         n_err++;
         $display("FAIL reset_data: got %h want 0", observed());
      end
      n_vec++;
      if (dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL reset_state: got %0d want 0", dbg_state);
      end
      // First edge after deassert must accept start: single-word 7FFF+1.
      rst = 1'b0;
      run_op(1'b0, 2'd0, 64'h7FFF, 64'h0001, 0, lat, obs, hold, extra);
      n_vec++;
      if (lat !== 2) begin
         n_err++;
         $display("FAIL single_lat: got %0d want 2", lat);
      end
      n_vec++;
      if (obs !== {64'h8000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
         n_err++;
         $display("FAIL single_res: got %h want %h", obs, {64'h8000, 5'b10001});
      end
   endtask

   task automatic test_directed();
      int          lat, extra;
      logic [68:0] obs, hold;
      // Carry chain across word boundary.
      run_op(1'b0, 2'd3, 64'h0000_0000_FFFF_FFFF, 64'd1, 0, lat, obs, hold, extra);
      n_vec++;
      if (lat !== 5) begin
         n_err++;
         $display("FAIL chain_lat: got %0d want 5", lat);
      end
      n_vec++;
      if (obs !== {64'h0000_0001_0000_0000, 5'b00000}) begin
         n_err++;
         $display("FAIL chain_res: got %h want %h", obs, {64'h0000_0001_0000_0000, 5'b00000});
      end
      n_vec++;
      if (hold !== obs || extra !== 0) begin
         n_err++;
         $display("FAIL chain_hold: got %h extra=%0d want %h extra=0", hold, extra, obs);
      end
      // Subtract to zero, two words; upper operand bits must be ignored.
      run_op(1'b1, 2'd1, 64'hAAAA_0000_1234_5678, 64'h5555_0000_1234_5678, 0, lat, obs, hold, extra);
      n_vec++;
      if (lat !== 3) begin
         n_err++;
         $display("FAIL subz_lat: got %0d want 3", lat);
      end
      n_vec++;
      if (obs !== {64'd0, 5'b01110}) begin
         n_err++;
         $display("FAIL subz_res: got %h want %h", obs, {64'd0, 5'b01110});
      end
   endtask

   task automatic test_start_ignored();
      int          lat, extra;
      logic [68:0] obs, hold;
      // Full wrap with start pulsed throughout RUN and DONE.
      run_op(1'b0, 2'd3, {64{1'b1}}, 64'd1, 1, lat, obs, hold, extra);
      n_vec++;
      if (lat !== 5) begin
         n_err++;
         $display("FAIL wrap_lat: got %0d want 5", lat);
      end
      n_vec++;
      if (obs !== {64'd0, 5'b01110}) begin
         n_err++;
         $display("FAIL wrap_res: got %h want %h", obs, {64'd0, 5'b01110});
      end
      n_vec++;
      if (extra !== 0 || hold !== obs || bus.busy !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_nosecond: extra=%0d busy=%b hold=%h want 0 0 %h",
                  extra, bus.busy, hold, obs);
      end
   endtask

   task automatic test_reset_mid();
      int          lat, extra, dones;
      logic [68:0] obs, hold, exp_r;
      bus.start  = 1'b1;
      bus.sub    = 1'b0;
      bus.nwords = 2'd3;
      bus.a      = 64'h1111_2222_3333_4444;
      bus.b      = 64'h0101_0202_0303_0404;
      @(negedge clk);            // RUN cycle 1
      bus.start = 1'b0;
      @(negedge clk);            // RUN cycle 2
      @(negedge clk);            // RUN cycle 3
      n_vec++;
      if (bus.z[31:0] !== 32'h3636_4848) begin
         n_err++;
         $display("FAIL mid_partial: got %h want 36364848", bus.z[31:0]);
      end
      #2 rst = 1'b1;
      #1;
      n_vec++;
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || observed() !== 69'd0 || dbg_state !== 2'd0) begin
         n_err++;
         $display("FAIL mid_reset: busy=%b done=%b data=%h state=%0d want all 0",
                  bus.busy, bus.done, observed(), dbg_state);
      end
      @(negedge clk);
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) dones++;
      end
      n_vec++;
      if (dones !== 0) begin
         n_err++;
         $display("FAIL mid_nodone: got %0d pulses want 0", dones);
      end
      run_op(1'b0, 2'd3, 64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404, 0, lat, obs, hold, extra);
      exp_r = model(1'b0, 2'd3, 64'h1111_2222_3333_4444, 64'h0101_0202_0303_0404);
      n_vec++;
      if (obs !== exp_r || lat !== 5) begin
         n_err++;
         $display("FAIL mid_after: got %h lat=%0d want %h lat=5", obs, lat, exp_r);
      end
   endtask

   task automatic test_stability();
      int          lat, extra;
      logic [68:0] obs, hold, exp_r;
      logic [63:0] a, b;
      logic        s;
      logic [1:0]  nw;
      for (int i = 0; i < 8; i++) begin
         a  = rand64();
         b  = rand64();
         s  = 1'($urandom_range(0, 1));
         nw = 2'($urandom_range(0, 3));
         run_op(s, nw, a, b, 2, lat, obs, hold, extra);
         exp_r = model(s, nw, a, b);
         n_vec++;
         if (obs !== exp_r || lat !== int'(nw) + 2) begin
            n_err++;
            $display("FAIL stable[%0d]: got %h lat=%0d want %h lat=%0d",
                     i, obs, lat, exp_r, int'(nw) + 2);
         end
      end
   endtask

   task automatic test_random();
      int          lat, extra;
      logic [68:0] obs, hold, exp_r;
      logic [63:0] a, b;
      logic        s;
      logic [1:0]  nw;
      for (int i = 0; i < 60; i++) begin
         s  = 1'($urandom_range(0, 1));
         nw = 2'($urandom_range(0, 3));
         case ($urandom_range(0, 3))
            0:       begin a = rand64(); b = a;          end
            1:       begin a = {64{1'b1}}; b = rand64(); end
            2:       begin a = {1'b0, {63{1'b1}}} >> (16 * (3 - int'(nw))); b = 64'd1; end
            default: begin a = rand64(); b = rand64();   end
         endcase
         run_op(s, nw, a, b, 0, lat, obs, hold, extra);
         exp_r = model(s, nw, a, b);
         n_vec++;
         if (obs !== exp_r || lat !== int'(nw) + 2 || hold !== exp_r || extra !== 0) begin
            n_err++;
            $display("FAIL rand[%0d] sub=%b nw=%0d: got %h lat=%0d hold=%h extra=%0d want %h lat=%0d",
                     i, s, nw, obs, lat, hold, extra, exp_r, int'(nw) + 2);
         end
      end
   endtask

   // ------------------------------------------------------------------
   // Sequence and report
   // ------------------------------------------------------------------
   initial begin
      n_vec      = 0;
      n_err      = 0;
      rst        = 1'b1;
      bus.start  = 1'b0;
      bus.sub    = 1'b0;
      bus.nwords = 2'd0;
      bus.a      = '0;
      bus.b      = '0;
      repeat (3) @(negedge clk);
      test_reset();
      test_directed();
      test_start_ignored();
      test_reset_mid();
      test_stability();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  request a new operation; sampled only in IDLE.
REQ-005 sub  input  1  operation select: 0 = A+B, 1 = A-B; captured on an accepted start.
REQ-006 nwords  input  2  operand length minus 1 (0 = 16 bits ... 3 = 64 bits); captured on an accepted start.
REQ-007 a  input  64  operand A, word k = a[16k+15:16k]; captured on an accepted start.
REQ-008 b  input  64  operand B, same word layout as a; captured on an accepted start.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 done  output  1  single-cycle pulse when the result and flags are final.
REQ-011 z  output  64  result; words above nwords are 0.
REQ-012 Sign, Zero, Carry, Parity, Overflow  output  1 each  status flags for the completed operation.

Function
REQ-013 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-014 IDLE with start=1: at the next edge, capture a, b, sub and nwords, clear z and all flags, set word index k=0, set carry-in to sub, and go to RUN.
REQ-015 IDLE with start=0: hold all outputs.
REQ-016 Each RUN cycle SHALL compute one 16-bit slice: {c_out, s} = A[k] + (sub ? ~B[k] : B[k]) + c_in, using one internal 16-bit add slice with carry-in.
REQ-017 At each RUN edge, s SHALL be written to z word k and c_out registered as the next c_in.
REQ-018 RUN: if k == nwords, go to DONE at the next edge; otherwise increment k.
REQ-019 Latency: exactly nwords+1 RUN cycles; done asserts on the cycle after the last word is written (start edge to done is nwords+2 cycles).
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-021 Carry SHALL be c_out of the top word (for sub, 1 means no borrow).
REQ-022 Sign SHALL be the MSB of the top word.
REQ-023 Zero SHALL be 1 iff all active result bits are 0.
REQ-024 Parity SHALL be the XNOR reduction of the active result bits (1 = even number of ones).
REQ-025 Overflow SHALL be computed from the top word: (Am & Bm' & ~Sm) | (~Am & ~Bm' & Sm), where Bm' is the MSB of the B operand after sub inversion.
REQ-026 Flags SHALL be registered at the final RUN edge and hold, with z, until the next accepted start.
REQ-027 start asserted in RUN or DONE SHALL be ignored, with no queuing; start in the same cycle done=1 is also ignored.
REQ-028 Changes on a, b, sub or nwords after capture SHALL NOT affect the operation in progress.
REQ-029 Wrap-around: unsigned overflow past the top word SHALL appear only on Carry; z words above nwords stay 0.

Reset
REQ-030 While rst=1, and immediately on assertion, the block SHALL force: state=IDLE, busy=0, done=0, z=0, all flags=0, k=0, c_in=0, captured operands=0.
REQ-031 Reset asserted mid-RUN SHALL abort the operation and produce no done pulse.
REQ-032 The first start SHALL be accepted on the first clk edge after rst deasserts.

Verification
REQ-033 Single word: start, sub=0, nwords=0, a=16'h7FFF, b=16'h0001 -> done 2 cycles after start; z=0x8000, Sign=1, Overflow=1, Carry=0, Zero=0, Parity=0.
REQ-034 Carry chain: nwords=3, a=64'h0000_0000_FFFF_FFFF, b=1 -> done at cycle 5; z=64'h0000_0001_0000_0000, Carry=0, Zero=0, Parity=0.
REQ-035 Subtract to zero: nwords=1, sub=1, a=b=32'h1234_5678 -> z=0, Zero=1, Carry=1, Overflow=0, Parity=1.
REQ-036 Full wrap: nwords=3, a=all ones, b=1 -> z=0, Carry=1, Zero=1; a start pulsed during RUN changes nothing and produces no second done.
REQ-037 Reset mid-operation: assert rst during the 3rd RUN cycle of a 4-word add -> immediately busy=0, z=0, flags=0; no done; the next start completes normally.
REQ-038 Operand stability: change a and b every cycle after start -> the result matches the values captured at start.
